// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between N_REQ requesters
module uart_tx_arbiter #(
    parameter int N_REQ    = 3,
    parameter int D_WIDTH  = 6,
    parameter int TO_WIDTH = 4,
    parameter int TIMEOUT  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*D_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]           ack,
    output logic [N_REQ-1:0]           grant,
    output logic                       frame_done,
    output logic                       uart_tx_ena,
    output logic [D_WIDTH-1:0]         uart_tx_data,
    input  logic                       uart_tx_busy,
    output logic                       timeout_err,
    input  logic                       err_clr
);
    localparam int PW = $clog2(N_REQ);
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state, state_d;
    logic [PW-1:0] ptr, ptr_d, owner, owner_d, win, nxt, j;
    logic [TO_WIDTH-1:0] cnt, cnt_d;
    logic [N_REQ-1:0] grant_d, ack_d, oh;
    logic done_d, ena_d, err_d;
    logic [D_WIDTH-1:0] data_d;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            cnt          <= '0;
            grant        <= '0;
            ack          <= '0;
            frame_done   <= 1'b0;
            uart_tx_ena  <= 1'b0;
            uart_tx_data <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_d;
            ptr          <= ptr_d;
            owner        <= owner_d;
            cnt          <= cnt_d;
            grant        <= grant_d;
            ack          <= ack_d;
            frame_done   <= done_d;
            uart_tx_ena  <= ena_d;
            uart_tx_data <= data_d;
            timeout_err  <= err_d;
        end
    end
    always_comb begin
        // descending scan so the lowest offset from ptr is the last, winning assignment
        win = ptr;
        j   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = PW'((int'(ptr) + i) % N_REQ);
            if (req[j]) win = j;
        end
        oh      = '0;
        oh[win] = 1'b1;
        nxt     = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
        state_d = state;
        ptr_d   = ptr;
        owner_d = owner;
        cnt_d   = cnt;
        grant_d = grant;
        ack_d   = '0;
        ena_d   = 1'b0;
        done_d  = 1'b0;
        data_d  = uart_tx_data;
        err_d   = timeout_err & ~err_clr;
        case (state)
            IDLE: if (|req) begin
                state_d = WAIT_BUSY;
                owner_d = win;
                grant_d = oh;
                ack_d   = oh;
                ena_d   = 1'b1;
                data_d  = req_data[win*D_WIDTH +: D_WIDTH];
                cnt_d   = '0;
            end
            WAIT_BUSY: if (uart_tx_busy) begin
                state_d = WAIT_DONE;
            end else if (cnt == TO_WIDTH'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                grant_d = '0;
                ptr_d   = nxt;
                state_d = IDLE;
            end else begin
                cnt_d = cnt + 1'b1;
            end
            WAIT_DONE: if (!uart_tx_busy) begin
                done_d  = 1'b1;
                grant_d = '0;
                ptr_d   = nxt;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner sequences and a randomized model comparison
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] req;
    logic [17:0] req_data;
    logic [2:0] ack, grant;
    logic frame_done, uart_tx_ena, uart_tx_busy, timeout_err, err_clr;
    logic [5:0] uart_tx_data;
    int tests = 0;
    int fails = 0;

    uart_tx_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .grant(grant),
        .frame_done(frame_done), .uart_tx_ena(uart_tx_ena), .uart_tx_data(uart_tx_data),
        .uart_tx_busy(uart_tx_busy), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic       busy;
        logic [2:0] grant;
        logic [2:0] ack;
        logic       ena;
        logic       done;
        logic [5:0] data;
    } vec_t;
    vec_t tbl[13];

    // transaction-level reference: owner index, whether busy was seen, cycles waited
    int m_owner, m_ptr, m_wait;
    bit m_seen, m_err;
    logic [5:0] m_data;
    logic [2:0] exp_grant, exp_ack;
    logic exp_ena, exp_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic frame(input int idx, input logic [5:0] d, input int blen, input bit drop);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!uart_tx_ena && n < 6);
        check("launch_ena", uart_tx_ena, 1);
        check("launch_grant", grant, 32'(1 << idx));
        check("launch_ack", ack, 32'(1 << idx));
        check("launch_data", uart_tx_data, d);
        if (drop) req[idx] = 1'b0;
        uart_tx_busy = 1'b1;
        for (int k = 0; k < blen; k++) begin
            tick();
            check("busy_hold", {grant, uart_tx_ena, frame_done, timeout_err}, {3'(1 << idx), 3'b000});
        end
        uart_tx_busy = 1'b0;
        tick();
        check("frame_done", {frame_done, uart_tx_ena, grant}, {1'b1, 1'b0, 3'b000});
    endtask

    task automatic model_step();
        int w = -1;
        bit nerr = err_clr ? 1'b0 : m_err;
        exp_ack  = '0;
        exp_ena  = 1'b0;
        exp_done = 1'b0;
        if (m_owner < 0) begin
            if (req != 0) begin
                for (int k = 0; k < 3; k++)
                    if (w < 0 && req[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
                m_owner = w;
                exp_ack = 3'(1 << w);
                exp_ena = 1'b1;
                m_data  = req_data[w*6 +: 6];
                m_seen  = 1'b0;
                m_wait  = 0;
            end
        end else if (!m_seen) begin
            if (uart_tx_busy) m_seen = 1'b1;
            else begin
                m_wait++;
                if (m_wait == 8) begin
                    nerr    = 1'b1;
                    m_ptr   = (m_owner + 1) % 3;
                    m_owner = -1;
                end
            end
        end else if (!uart_tx_busy) begin
            exp_done = 1'b1;
            m_ptr    = (m_owner + 1) % 3;
            m_owner  = -1;
        end
        m_err     = nerr;
        exp_grant = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    endtask

    initial begin
        int bcnt;
        tbl[0]  = '{3'b001, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 6'h2A};
        tbl[1]  = '{3'b000, 1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 6'h2A};
        tbl[2]  = '{3'b000, 1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 6'h2A};
        tbl[3]  = '{3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 6'h2A};
        tbl[4]  = '{3'b011, 1'b0, 3'b010, 3'b010, 1'b1, 1'b0, 6'h15};
        tbl[5]  = '{3'b000, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0, 6'h15};
        tbl[6]  = '{3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 6'h15};
        tbl[7]  = '{3'b011, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 6'h2A};
        tbl[8]  = '{3'b000, 1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 6'h2A};
        tbl[9]  = '{3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 6'h2A};
        tbl[10] = '{3'b100, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0, 6'h3F};
        tbl[11] = '{3'b000, 1'b1, 3'b100, 3'b000, 1'b0, 1'b0, 6'h3F};
        tbl[12] = '{3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 6'h3F};
        rst = 1'b0;
        req = '0;
        req_data = {6'h3F, 6'h15, 6'h2A};
        uart_tx_busy = 1'b0;
        err_clr = 1'b0;
        #12;
        check("reset_state", {ack, grant, frame_done, uart_tx_ena, uart_tx_data, timeout_err}, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 13; i++) begin
            req = tbl[i].req;
            uart_tx_busy = tbl[i].busy;
            tick();
            check($sformatf("vec%0d_grant", i), grant, tbl[i].grant);
            check($sformatf("vec%0d_ack", i), ack, tbl[i].ack);
            check($sformatf("vec%0d_ena", i), uart_tx_ena, tbl[i].ena);
            check($sformatf("vec%0d_done", i), frame_done, tbl[i].done);
            check($sformatf("vec%0d_data", i), uart_tx_data, tbl[i].data);
        end
        req = '0;
        // simultaneous requests served 0,1,2
        req_data = {6'h03, 6'h02, 6'h01};
        req = 3'b111;
        frame(0, 6'h01, 2, 1);
        frame(1, 6'h02, 3, 1);
        frame(2, 6'h03, 1, 1);
        // two persistent requesters alternate
        req = 3'b110;
        frame(1, 6'h02, 2, 0);
        frame(2, 6'h03, 1, 0);
        frame(1, 6'h02, 1, 0);
        frame(2, 6'h03, 2, 0);
        req = '0;
        // launch timeout, then clear
        req = 3'b010;
        tick();
        check("to_launch", {grant, uart_tx_ena}, {3'b010, 1'b1});
        req = '0;
        for (int k = 1; k < 8; k++) begin
            tick();
            check("to_wait", {timeout_err, grant, frame_done}, {1'b0, 3'b010, 1'b0});
        end
        tick();
        check("to_fire", {timeout_err, grant, frame_done}, {1'b1, 3'b000, 1'b0});
        err_clr = 1'b1;
        tick();
        check("to_clear", timeout_err, 0);
        err_clr = 1'b0;
        // timeout coinciding with err_clr: set wins
        req = 3'b010;
        tick();
        check("to2_launch", {grant, uart_tx_ena}, {3'b010, 1'b1});
        req = '0;
        for (int k = 1; k < 8; k++) tick();
        err_clr = 1'b1;
        tick();
        check("to2_set_wins", {timeout_err, grant}, {1'b1, 3'b000});
        tick();
        check("to2_clear", timeout_err, 0);
        err_clr = 1'b0;
        // asynchronous reset mid-frame
        req = 3'b001;
        tick();
        check("rst_launch", grant, 3'b001);
        req = '0;
        uart_tx_busy = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", {ack, grant, frame_done, uart_tx_ena, uart_tx_data, timeout_err}, 0);
        tick();
        check("rst_no_done", frame_done, 0);
        rst = 1'b1;
        uart_tx_busy = 1'b0;
        req = 3'b100;
        frame(2, 6'h03, 20, 1);
        // randomized comparison against the transaction model
        rst = 1'b0;
        req = '0;
        err_clr = 1'b0;
        tick();
        rst = 1'b1;
        m_owner = -1;
        m_ptr = 0;
        m_err = 1'b0;
        m_seen = 1'b0;
        m_wait = 0;
        m_data = '0;
        bcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            model_step();
            tick();
            check("rnd_grant", grant, exp_grant);
            check("rnd_ack", ack, exp_ack);
            check("rnd_ena", uart_tx_ena, exp_ena);
            check("rnd_done", frame_done, exp_done);
            check("rnd_err", timeout_err, m_err);
            check("rnd_data", uart_tx_data, m_data);
            if (exp_ena) begin
                bcnt = ($urandom % 8 == 0) ? 0 : 1 + int'($urandom % 6);
                uart_tx_busy = bcnt > 0;
            end else if (bcnt > 0) begin
                bcnt--;
                uart_tx_busy = bcnt > 0;
            end
            for (int i = 0; i < 3; i++) begin
                if (exp_ack[i]) begin
                    req[i] = $urandom % 2;
                    req_data[i*6 +: 6] = 6'($urandom);
                end else if (!req[i] && $urandom % 4 == 0) begin
                    req[i] = 1'b1;
                    req_data[i*6 +: 6] = 6'($urandom);
                end
            end
            err_clr = ($urandom % 10 == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter (6-bit data, tx_ena/tx_busy handshake) between N_REQ independent requesters.
- Latches the winning requester's word and issues a single-cycle tx_ena pulse to the transmitter.
- Tracks the frame via tx_busy until the transmitter returns idle.
- Flags a sticky error if the transmitter never acknowledges a launch.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- D_WIDTH, 6, data word width; matches the transmitter data port
- TO_WIDTH, 4, width of the launch-timeout counter
- TIMEOUT, 8, cycles to wait in WAIT_BUSY for tx_busy before declaring a timeout (must be < 2**TO_WIDTH)

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request, level; held high until the matching ack
- req_data  in  N_REQ*D_WIDTH  requester i data at bits [i*D_WIDTH +: D_WIDTH]; stable while req[i] is high
- ack  out  N_REQ  one-hot, one-cycle pulse; requester's word accepted
- grant  out  N_REQ  one-hot owner of the transmitter, held for the whole frame; 0 when idle
- frame_done  out  1  one-cycle pulse when the granted frame completes
- uart_tx_ena  out  1  to transmitter tx_ena
- uart_tx_data  out  D_WIDTH  to transmitter tx_data
- uart_tx_busy  in  1  from transmitter tx_busy
- timeout_err  out  1  sticky launch-timeout flag
- err_clr  in  1  synchronous clear of timeout_err

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous):
  - State is IDLE; all outputs are 0.
  - uart_tx_data = 0; round-robin pointer ptr = 0; timeout counter = 0.
  - Reset mid-frame abandons the frame with no frame_done.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If req != 0, pick the winner w = first set bit of req, scanning from ptr upward and wrapping at N_REQ.
  - On that edge: grant <= onehot(w), ack <= onehot(w), uart_tx_ena <= 1, uart_tx_data <= req_data slice w, counter <= 0, state <= WAIT_BUSY.
  - If req == 0, stay in IDLE with all pulses at 0.
- WAIT_BUSY:
  - uart_tx_ena and ack are 0 from the second cycle; tx_ena is high exactly one cycle.
  - If uart_tx_busy = 1: state <= WAIT_DONE.
  - Else, if counter == TIMEOUT-1: timeout_err <= 1, grant <= 0, ptr <= (w+1) mod N_REQ, state <= IDLE.
  - Else: counter increments.
  - Nominal path: busy is seen in the cycle after the tx_ena pulse.
- WAIT_DONE:
  - Wait for uart_tx_busy = 0.
  - On that edge: frame_done <= 1, grant <= 0, ptr <= (w+1) mod N_REQ, state <= IDLE.
- Minimum spacing: the next launch is at least one IDLE cycle after frame_done. tx_ena is never high while the transmitter is busy, so the transmitter never auto-restarts on a held enable.
- Requester rules:
  - After ack, req[i] still high is a new request with fresh data.
  - It is eligible only via round-robin, so ptr has moved past i.
  - req changes while granted are ignored; data was latched at launch.
- Fairness: a continuously requesting source waits at most N_REQ-1 frames.
- timeout_err:
  - err_clr=1 clears it.
  - If a new timeout and err_clr occur on the same edge, set wins (flag = 1).
  - timeout_err does not block further arbitration.
- uart_tx_data holds its last launched value between frames.

Test Plan:
- Single request: req=001, data0=6'h2A. Required response:
  - ack=001 and uart_tx_ena=1 for one cycle, with uart_tx_data=6'h2A.
  - grant=001 until busy falls.
  - frame_done pulse; ptr=1.
- Simultaneous requests: req=111 with data 6'h01/6'h02/6'h03. Required response:
  - Launch order is requester 0, 1, 2; tx_data is 01, 02, 03.
  - Three frame_done pulses; at least one IDLE cycle between frames.
- Fairness: req[1] held high continuously with req[2] high. Required response: grants alternate 010, 100, 010, …; no requester is starved.
- Timeout: uart_tx_busy tied 0, req=010. Required response:
  - After TIMEOUT=8 cycles in WAIT_BUSY, timeout_err=1 and grant=0, with no frame_done.
  - err_clr then gives timeout_err=0.
  - A repeat with err_clr asserted on the timeout edge gives timeout_err=1.
- Reset mid-frame: rst=0 during WAIT_DONE. Required response:
  - All outputs are 0 immediately (asynchronous), with no frame_done.
  - After release, req=100 gives a grant to requester 2 (ptr=0 scan).
- Busy held long: transmitter busy for 20 cycles. Required response:
  - The block stays in WAIT_DONE with no timeout and tx_ena=0 throughout.
  - frame_done arrives one edge after busy falls.
